// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, fetch FSM encoding and the NOP word.
package cpu_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// Sequential next-PC incrementer: word address + 1, modulo 2^PC_W.
module pc_adder
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  output logic [PC_W-1:0] o_pc_inc
);

  assign o_pc_inc = i_pc + PC_W'(1);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch controller; captures imem data into IF/ID
// and selects next PC (redirect > stall > sequential).
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               fault
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [PC_W-1:0]     w_pc_inc;
  logic                r_if_valid;
  logic                w_if_valid_nxt;
  logic [PC_W-1:0]     r_if_pc;
  logic [PC_W-1:0]     w_if_pc_nxt;
  logic [INSTR_W-1:0]  r_if_instr;
  logic [INSTR_W-1:0]  w_if_instr_nxt;
  logic                r_fault;
  logic                w_fault_nxt;
  logic                w_active;
  logic                w_in_range;

  pc_adder u_pc_adder (
    .i_pc     (r_pc),
    .o_pc_inc (w_pc_inc)
  );

  assign w_active   = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign w_in_range = r_pc < PC_W'(IMEM_WORDS);

  // An out-of-range PC never reaches memory; the FSM faults instead.
  assign imem_req  = !reset && w_active && w_in_range;
  assign imem_addr = r_pc;

  assign pc       = r_pc;
  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign fault    = r_fault;

  // Next-state and IF/ID update: halt > range fault > redirect > stall > ready.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_fault_nxt    = r_fault;
    case (r_state)
      ST_FETCH, ST_WAIT: begin
        if (halt_req) begin
          w_state_nxt    = ST_HALT;
          w_if_valid_nxt = 1'b0;
        end else if (!w_in_range) begin
          w_state_nxt    = ST_FAULT;
          w_fault_nxt    = 1'b1;
          w_if_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          w_state_nxt    = ST_FETCH;
          w_pc_nxt       = redirect_pc;
          w_if_valid_nxt = 1'b0;
        end else if (stall) begin
          w_state_nxt    = r_state;
        end else if (imem_ready) begin
          w_state_nxt    = ST_FETCH;
          w_pc_nxt       = w_pc_inc;
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = imem_rdata;
        end else begin
          w_state_nxt    = ST_WAIT;
          w_if_valid_nxt = 1'b0;
        end
      end
      ST_HALT, ST_FAULT: begin
        w_if_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP_INSTR;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; imem returns a fixed pattern XORed with the address.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] PAT = 32'hA500_0000;

  pc_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fault(fault)
  );

  always #5 clk = ~clk;
  assign imem_rdata = PAT ^ imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_if_instr: got %h want 00000013", if_instr); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, if_valid); end
      n_cmp++; if (if_pc !== 32'(i)) begin n_err++; $display("FAIL seq_if_pc[%0d]: got %h want %h", i, if_pc, 32'(i)); end
      n_cmp++; if (if_instr !== (PAT ^ 32'(i))) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", i, if_instr, PAT ^ 32'(i)); end
    end
    n_cmp++; if (pc !== 32'd4) begin n_err++; $display("FAIL seq_pc: got %h want 4", pc); end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d]: got %b want 0", i, if_valid); end
      n_cmp++; if (imem_addr !== 32'd4) begin n_err++; $display("FAIL wait_addr[%0d]: got %h want 4", i, imem_addr); end
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
    end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd4) begin n_err++; $display("FAIL wait_resume: got v=%b pc=%h want v=1 pc=4", if_valid, if_pc); end
    tick();
    n_cmp++; if (if_pc !== 32'd5 || pc !== 32'd6) begin n_err++; $display("FAIL wait_next: got if_pc=%h pc=%h want 5/6", if_pc, pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd5 || pc !== 32'd6) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b if_pc=%h pc=%h want 1/5/6", i, if_valid, if_pc, pc);
      end
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 1", i, imem_req); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'd6 || if_instr !== (PAT ^ 32'd6) || pc !== 32'd7) begin
      n_err++; $display("FAIL stall_release: got if_pc=%h instr=%h pc=%h want 6/%h/7", if_pc, if_instr, pc, PAT ^ 32'd6);
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    n_cmp++; if (pc !== 32'h40 || if_valid !== 1'b0) begin n_err++; $display("FAIL redir_squash: got pc=%h v=%b want 40/0", pc, if_valid); end
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'h40 || if_valid !== 1'b1 || pc !== 32'h41) begin
      n_err++; $display("FAIL redir_fetch: got if_pc=%h v=%b pc=%h want 40/1/41", if_pc, if_valid, pc);
    end
  endtask

  task automatic test_range_boundary();
    redirect_valid = 1'b1; redirect_pc = 32'd1023;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL last_word_req: got %b want 1", imem_req); end
    tick();
    n_cmp++; if (if_pc !== 32'd1023 || if_valid !== 1'b1 || fault !== 1'b0) begin
      n_err++; $display("FAIL last_word_fetch: got if_pc=%h v=%b f=%b want 3ff/1/0", if_pc, if_valid, fault);
    end
    n_cmp++; if (pc !== 32'd1024 || imem_req !== 1'b0) begin n_err++; $display("FAIL last_word_wrap_req: got pc=%h req=%b want 400/0", pc, imem_req); end
    tick();
    n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL last_word_fault: got f=%b v=%b want 1/0", fault, if_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_fault();
    imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd1024;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'd1024 || imem_req !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL fault_target: got pc=%h req=%b f=%b want 400/0/0", pc, imem_req, fault);
    end
    tick();
    n_cmp++; if (fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL fault_set: got f=%b req=%b v=%b want 1/0/0", fault, imem_req, if_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (fault !== 1'b1 || pc !== 32'd1024 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL fault_sticky[%0d]: got f=%b pc=%h req=%b want 1/400/0", i, fault, pc, imem_req);
      end
    end
    redirect_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (fault !== 1'b0 || pc !== 32'd0) begin n_err++; $display("FAIL fault_clear: got f=%b pc=%h want 0/0", fault, pc); end
  endtask

  task automatic test_halt();
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'd2) begin
        n_err++; $display("FAIL halt_hold[%0d]: got req=%b v=%b pc=%h want 0/0/2", i, imem_req, if_valid, pc);
      end
    end
    redirect_valid = 1'b0; imem_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; #1;
    n_cmp++; if (pc !== 32'd0 || imem_req !== 1'b1) begin n_err++; $display("FAIL halt_reset: got pc=%h req=%b want 0/1", pc, imem_req); end
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0; imem_ready = 1'b1;
    n_cmp++; if (pc !== 32'd0 || if_valid !== 1'b0) begin n_err++; $display("FAIL wait_reset: got pc=%h v=%b want 0/0", pc, if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || pc !== 32'd1) begin
      n_err++; $display("FAIL resume_fetch: got v=%b if_pc=%h pc=%h want 1/0/1", if_valid, if_pc, pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_redirect();
    test_range_boundary();
    test_fault();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
